// File: rtl/z_buffer_pkg.sv
// Shared types and constants for the z_buffer depth-test client and its depth-store responder.
package z_buffer_pkg;

  typedef enum logic [2:0] {
    Z_NEVER    = 3'd0,
    Z_LESS     = 3'd1,
    Z_EQUAL    = 3'd2,
    Z_LEQUAL   = 3'd3,
    Z_GREATER  = 3'd4,
    Z_NOTEQUAL = 3'd5,
    Z_GEQUAL   = 3'd6,
    Z_ALWAYS   = 3'd7
  } z_func_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    WR_ACK  = 2'd3
  } zmem_state_t;

  localparam int Z_MAX_SIZE = 64;
  // Sliced down to Z_SIZE by users; returned for misses and cleared entries.
  localparam logic [Z_MAX_SIZE-1:0] Z_CLEAR_VALUE = {Z_MAX_SIZE{1'b1}};

endpackage

// File: rtl/z_buffer_mem_if.sv
// Read/write handshake between the z_buffer client (master) and the depth store (slave).
interface z_buffer_mem_if #(
  parameter int Z_SIZE    = 8,
  parameter int ADDR_SIZE = 32
);
  logic                 buf_r_w;
  logic [ADDR_SIZE-1:0] buf_addr;
  logic [Z_SIZE-1:0]    buf_data_w;
  logic [Z_SIZE-1:0]    buf_data_r;
  logic                 data_r_ready;
  logic                 data_r_valid;
  logic                 data_w_valid;
  logic                 data_w_ready;

  modport master (
    output buf_r_w, buf_addr, buf_data_w, data_r_ready, data_w_valid,
    input  buf_data_r, data_r_valid, data_w_ready
  );

  modport slave (
    input  buf_r_w, buf_addr, buf_data_w, data_r_ready, data_w_valid,
    output buf_data_r, data_r_valid, data_w_ready
  );
endinterface

// File: rtl/zbuf_sram.sv
// Single-port synchronous RAM with a registered read port; contents are never reset.
module zbuf_sram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read; q only moves when a read is issued so it holds through the response
  always_ff @(posedge clk) begin
    if (re) begin
      q <= mem[addr];
    end
  end
endmodule

// File: rtl/z_buffer_mem.sv
// Depth-store responder: serialises z_buffer read/write requests onto a DEPTH x Z_SIZE RAM.
// Optional fast clear of all entries is enabled by defining ZBUF_MEM_FAST_CLEAR_EN.
module z_buffer_mem
  import z_buffer_pkg::*;
#(
  parameter int Z_SIZE    = 8,
  parameter int X_RES     = 4,
  parameter int Y_RES     = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DEPTH     = X_RES * Y_RES,
  parameter int IDX_SIZE  = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE-1:0] buffer_base_address_i,
`ifdef ZBUF_MEM_FAST_CLEAR_EN
  input  logic                 clear_i,
`endif
  z_buffer_mem_if.slave        bus,
  output logic                 oob_err_o,
  output logic                 busy_o
);

  zmem_state_t          state;
  logic [ADDR_SIZE-1:0] off;
  logic                 in_range;
  logic [IDX_SIZE-1:0]  idx;
  logic                 idle;
  logic                 rd_req;
  logic                 wr_req;
  logic                 clr_now;
  logic                 take_rd;
  logic                 take_wr;
  logic                 ram_we;
  logic                 entry_ok;
  logic                 rd_ok;
  logic [Z_SIZE-1:0]    ram_q;

`ifdef ZBUF_MEM_FAST_CLEAR_EN
  logic [DEPTH-1:0]     valid;
  logic                 clear_pend;
`endif

  // Address translation, request qualification and RAM control
  always_comb begin
    off      = bus.buf_addr - buffer_base_address_i;
    in_range = (off < ADDR_SIZE'(DEPTH));
    idx      = off[IDX_SIZE-1:0];
    idle     = (state == IDLE);
    rd_req   = bus.data_r_ready && bus.buf_r_w;
    wr_req   = bus.data_w_valid && !bus.buf_r_w;
`ifdef ZBUF_MEM_FAST_CLEAR_EN
    clr_now  = idle && (clear_i || clear_pend);
    entry_ok = in_range && valid[idx];
`else
    clr_now  = 1'b0;
    entry_ok = in_range;
`endif
    // A pending or fresh clear takes the IDLE slot; the request is sampled next cycle
    take_rd  = idle && !clr_now && rd_req;
    take_wr  = idle && !clr_now && wr_req;
    ram_we   = take_wr && in_range;
  end

  zbuf_sram #(
    .WIDTH (Z_SIZE),
    .DEPTH (DEPTH),
    .AW    (IDX_SIZE)
  ) u_sram (
    .clk   (clk_i),
    .we    (ram_we),
    .re    (take_rd),
    .addr  (idx),
    .wdata (bus.buf_data_w),
    .q     (ram_q)
  );

  // Access FSM with registered handshake outputs and sticky range error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      bus.buf_data_r   <= '0;
      bus.data_r_valid <= 1'b0;
      bus.data_w_ready <= 1'b0;
      oob_err_o        <= 1'b0;
      busy_o           <= 1'b0;
      rd_ok            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_rd) begin
            state  <= RD_WAIT;
            busy_o <= 1'b1;
            rd_ok  <= entry_ok;
            if (!in_range) oob_err_o <= 1'b1;
          end else if (take_wr) begin
            state            <= WR_ACK;
            busy_o           <= 1'b1;
            bus.data_w_ready <= 1'b1;
            if (!in_range) oob_err_o <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        RD_WAIT: begin
          bus.buf_data_r   <= rd_ok ? ram_q : Z_CLEAR_VALUE[Z_SIZE-1:0];
          bus.data_r_valid <= 1'b1;
          state            <= RD_RESP;
        end
        RD_RESP: begin
          bus.data_r_valid <= 1'b0;
          busy_o           <= 1'b0;
          state            <= IDLE;
        end
        WR_ACK: begin
          bus.data_w_ready <= 1'b0;
          busy_o           <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          bus.data_r_valid <= 1'b0;
          bus.data_w_ready <= 1'b0;
          busy_o           <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

`ifdef ZBUF_MEM_FAST_CLEAR_EN
  // Per-entry valid bits; clear requests arriving while busy are held until IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid      <= '0;
      clear_pend <= 1'b0;
    end else if (clr_now) begin
      valid      <= '0;
      clear_pend <= 1'b0;
    end else begin
      if (ram_we) valid[idx] <= 1'b1;
      if (!idle && clear_i) clear_pend <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_z_buffer_mem.sv
// Scoreboard bench for z_buffer_mem: driver pushes expected responses, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_z_buffer_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] base;
  logic        oob;
  logic        busy;
`ifdef ZBUF_MEM_FAST_CLEAR_EN
  logic        clear = 1'b0;
`endif

  z_buffer_mem_if #(.Z_SIZE(8), .ADDR_SIZE(32)) bus ();

  z_buffer_mem dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .buffer_base_address_i (base),
`ifdef ZBUF_MEM_FAST_CLEAR_EN
    .clear_i               (clear),
`endif
    .bus                   (bus),
    .oob_err_o             (oob),
    .busy_o                (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    int         seen;
  } exp_t;
  exp_t exq[$];

  // Reference model: what each entry holds, sticky error flag, first edge the responder is free
  logic [7:0] model_mem [16];
  bit         model_oob = 1'b0;
  int         free_at = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.data_r_valid || bus.data_w_ready)) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got r=%0b w=%0b expected no response", bus.data_r_valid, bus.data_w_ready);
      end else begin
        e = exq.pop_front();
        chk("resp_kind", {31'd0, bus.data_r_valid}, {31'd0, e.rd});
        chk("resp_excl", {31'd0, bus.data_r_valid & bus.data_w_ready}, 32'd0);
        if (e.rd) chk("rd_data", {24'd0, bus.buf_data_r}, {24'd0, e.data});
        chk("resp_cycle", 32'(cyc), 32'(e.seen));
        chk("busy_on_resp", {31'd0, busy}, 32'd1);
      end
    end
  end

  // Applies a request at the current negedge and holds it until its response is seen
  task automatic issue(input bit rd, input logic [31:0] addr, input logic [7:0] wd, input bit both);
    int         s;
    logic [31:0] off;
    logic [7:0] e;
    int         waited;
    bit         resp;
    bus.buf_r_w      = rd;
    bus.buf_addr     = addr;
    bus.buf_data_w   = wd;
    bus.data_r_ready = rd | both;
    bus.data_w_valid = !rd | both;
    s = (cyc + 1 > free_at) ? cyc + 1 : free_at;
    free_at = s + (rd ? 3 : 2);
    off = addr - base;
    if (off < 32'd16) begin
      if (!rd) model_mem[off[3:0]] = wd;
      e = model_mem[off[3:0]];
    end else begin
      e = 8'hFF;
      model_oob = 1'b1;
    end
    exq.push_back('{rd: rd, data: e, seen: s + (rd ? 1 : 0)});
    waited = 0;
    resp = 1'b0;
    while (!resp && waited < 12) begin
      @(negedge clk);
      waited++;
      resp = rd ? bus.data_r_valid : bus.data_w_ready;
    end
    if (!resp) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no response after %0d cycles expected one for addr %0h", waited, addr);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    bus.data_r_ready = 1'b0;
    bus.data_w_valid = 1'b0;
  endtask

`ifdef ZBUF_MEM_FAST_CLEAR_EN
  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'hFF;
  endtask
`endif

  logic [31:0] raddr;
  int          r;

  initial begin
    base = 32'h100;
    bus.buf_r_w = 1'b0;
    bus.buf_addr = '0;
    bus.buf_data_w = '0;
    bus.data_r_ready = 1'b0;
    bus.data_w_valid = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'hFF;

    #2 rst = 1'b1;
    #3;
    chk("rst_valid", {31'd0, bus.data_r_valid}, 32'd0);
    chk("rst_ready", {31'd0, bus.data_w_ready}, 32'd0);
    chk("rst_data",  {24'd0, bus.buf_data_r}, 32'd0);
    chk("rst_oob",   {31'd0, oob}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    free_at = cyc + 1;

    // Basic write then read of the same entry
    issue(1'b0, 32'h105, 8'h3C, 1'b0);
    drop();
    issue(1'b1, 32'h105, 8'h00, 1'b0);
    drop();
    chk("oob_clean", {31'd0, oob}, 32'd0);

    // Flush stream with the write strobe held continuously, then read everything back
    for (int i = 0; i < 16; i++) issue(1'b0, 32'h100 + 32'(i), 8'hFF, 1'b0);
    drop();
    for (int i = 0; i < 16; i++) issue(1'b1, 32'h100 + 32'(i), 8'h00, 1'b0);
    drop();
    issue(1'b0, 32'h10F, 8'h5A, 1'b0);
    drop();

    // Out-of-range read and write; entry 15 must keep 0x5A
    issue(1'b1, 32'h110, 8'h00, 1'b0);
    drop();
    chk("oob_after_rd", {31'd0, oob}, {31'd0, model_oob});
    issue(1'b0, 32'h0FF, 8'h77, 1'b0);
    drop();
    issue(1'b1, 32'h10F, 8'h00, 1'b0);
    drop();
    chk("oob_sticky", {31'd0, oob}, {31'd0, model_oob});

    // Reset while a read sits in RD_WAIT: no response, outputs clear at once
    drop();
    bus.buf_r_w = 1'b1;
    bus.buf_addr = 32'h105;
    bus.data_r_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, bus.data_r_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.data_w_ready}, 32'd0);
    chk("mid_rst_data",  {24'd0, bus.buf_data_r}, 32'd0);
    chk("mid_rst_oob",   {31'd0, oob}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    bus.data_r_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_oob = 1'b0;
    free_at = cyc + 1;
    repeat (3) @(negedge clk);
    issue(1'b0, 32'h105, 8'hA5, 1'b0);
    issue(1'b1, 32'h105, 8'h00, 1'b0);
    drop();

    // Randomised traffic, including a base near the top of the address space
    for (int n = 0; n < 70; n++) begin
      if (n == 40) begin
        drop();
        repeat (2) @(negedge clk);
        base = 32'hFFFF_FFF8;
      end
      r = int'($urandom_range(0, 9));
      if (r < 8)       raddr = base + 32'($urandom_range(0, 15));
      else if (r == 8) raddr = base + 32'd16 + 32'($urandom_range(0, 3));
      else             raddr = base - 32'd1 - 32'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), raddr, 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        drop();
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
    end
    drop();
    chk("oob_final", {31'd0, oob}, {31'd0, model_oob});
    base = 32'h100;
    drop();

`ifdef ZBUF_MEM_FAST_CLEAR_EN
    // Clear in IDLE, then read back a previously written entry
    issue(1'b0, 32'h103, 8'h10, 1'b0);
    drop();
    clear = 1'b1;
    r = (cyc + 1 > free_at) ? cyc + 1 : free_at;
    free_at = r + 1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    issue(1'b1, 32'h103, 8'h00, 1'b0);
    drop();
    // Clear during WR_ACK is deferred and serviced before the following read
    issue(1'b0, 32'h104, 8'h55, 1'b0);
    clear = 1'b1;
    fork
      begin
        @(negedge clk);
        clear = 1'b0;
      end
    join_none
    free_at = free_at + 1;
    model_clear();
    issue(1'b1, 32'h104, 8'h00, 1'b0);
    drop();
    issue(1'b0, 32'h106, 8'h66, 1'b0);
    issue(1'b1, 32'h106, 8'h00, 1'b0);
    drop();
`endif

    for (int k = 0; k < 10 && exq.size() != 0; k++) @(negedge clk);
    chk("queue_drained", 32'(exq.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
